// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt pending controller.
// Eight channels, binary 3-bit channel index.
package irq_pkg;
    localparam int N_CH = 8;
    localparam int ID_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;
endpackage

// File: rtl/irq_pend_ctrl_if.sv
// Request presentation handshake: controller drives valid/id, consumer returns ack.
// id is held stable for as long as valid is high.
interface irq_pend_ctrl_if;
    import irq_pkg::*;

    logic            irq_valid;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;

    modport master (output irq_valid, output irq_id, input irq_ack);
    modport slave  (input irq_valid, input irq_id, output irq_ack);
endinterface

// File: rtl/prio_enc8.sv
// Combinational priority encoder: index of the highest set bit, plus an any-set flag.
// Zero latency, no state.
module prio_enc8
    import irq_pkg::*;
(
    input  logic [N_CH-1:0] vec,
    output logic [ID_W-1:0] idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Ascending scan so the highest set bit is the last one to write idx.
        for (int i = 0; i < N_CH; i++) begin
            if (vec[i]) begin
                idx = ID_W'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/irq_pend_ctrl.sv
// Synchronizes raw request lines, latches rising edges into a pending register and
// presents the highest-priority enabled request, holding it until acknowledged.
module irq_pend_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2  // legal range 2..3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     irq_in,
    input  logic [N_CH-1:0]     mask,
    output logic [N_CH-1:0]     pend,
    irq_pend_ctrl_if.master     irq
);
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] hist_q;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] pend_q;
    logic [N_CH-1:0] pend_nxt;
    logic [N_CH-1:0] clr;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] sel_idx;
    logic            sel_any;
    logic            load_id;
    logic            ack_take;
    state_t          state_q;
    state_t          state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // History resets to 0, so a line already high at reset release counts as a rise.
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    // A rise on the channel being acked in the same cycle keeps it pending.
    assign clr      = ack_take ? (N_CH'(1) << id_q) : '0;
    assign pend_nxt = (pend_q & ~clr) | rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
        end
    end

    prio_enc8 u_prio_enc8 (
        .vec (pend_q & mask),
        .idx (sel_idx),
        .any (sel_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_nxt;
            if (load_id) begin
                id_q <= sel_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (sel_any) state_nxt = PRESENT;
            PRESENT: if (irq.irq_ack) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        irq.irq_valid = (state_q == PRESENT);
        ack_take      = (state_q == PRESENT) && irq.irq_ack;
        load_id       = (state_q == IDLE) && sel_any;
    end

    assign irq.irq_id = id_q;
    assign pend       = pend_q;
endmodule
